// File: rtl/kernel_coeff_scheduler.sv
// Sequences a kernel generator (clear, generate, load) and arbitrates two read ports into the coefficient bank.
// Optional generation watchdog: define KSCHED_TIMEOUT_EN.
module kernel_coeff_scheduler #(
  parameter int SIZE    = 5,
  parameter int COEF_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  output logic                            gen_reset,
  output logic                            gen_enable,
  input  logic                            gen_done,
  input  logic [SIZE*SIZE*COEF_W-1:0]     gen_kernel,
  input  logic                            req0,
  input  logic                            req1,
  input  logic [$clog2(SIZE*SIZE)-1:0]    addr0,
  input  logic [$clog2(SIZE*SIZE)-1:0]    addr1,
  output logic                            gnt0,
  output logic                            gnt1,
  output logic                            rvalid0,
  output logic                            rvalid1,
  output logic [COEF_W-1:0]               rdata,
  output logic                            addr_err,
  output logic                            kernel_valid,
  output logic                            err
);

  localparam int unsigned N  = SIZE * SIZE;
  localparam int unsigned AW = $clog2(N);
  localparam logic [AW:0] N_L = (AW+1)'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_GEN,
    S_LOAD,
    S_READY,
    S_ERR
  } state_t;

  state_t            state, state_nx;
  logic              ptr;  // 0: req0 wins a tie, 1: req1 wins a tie
  logic [COEF_W-1:0] bank [N];
  logic [AW-1:0]     sel_addr;
  logic              in_range;

`ifdef KSCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`endif

  always_comb begin
    state_nx     = state;
    gen_reset    = 1'b0;
    gen_enable   = 1'b0;
    kernel_valid = 1'b0;
    err          = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_CLR;
      end
      S_CLR: begin
        gen_reset = 1'b1;
        state_nx  = S_GEN;
      end
      S_GEN: begin
        gen_enable = 1'b1;
        if (gen_done) state_nx = S_LOAD;
`ifdef KSCHED_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) state_nx = S_ERR;
`endif
      end
      S_LOAD: begin
        state_nx = S_READY;
      end
      S_READY: begin
        kernel_valid = 1'b1;
        if (req0 && (!req1 || !ptr)) gnt0 = 1'b1;
        else if (req1)               gnt1 = 1'b1;
        if (start) state_nx = S_CLR;
      end
      S_ERR: begin
`ifdef KSCHED_TIMEOUT_EN
        err = 1'b1;
`endif
        if (start) state_nx = S_CLR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

`ifdef KSCHED_TIMEOUT_EN
  // Cleared while in CLR so every GEN visit starts counting from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (state == S_CLR) begin
      tcnt <= '0;
    end else if (state == S_GEN) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N; i++) bank[i] <= '0;
    end else if (state == S_LOAD) begin
      for (int unsigned i = 0; i < N; i++) bank[i] <= gen_kernel[i*COEF_W +: COEF_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b0;
    end else if (gnt0) begin
      ptr <= 1'b1;
    end else if (gnt1) begin
      ptr <= 1'b0;
    end
  end

  always_comb begin
    sel_addr = gnt1 ? addr1 : addr0;
    in_range = {1'b0, sel_addr} < N_L;
  end

  // Read port: one-cycle latency, all outputs return to zero when nothing was granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= '0;
      addr_err <= 1'b0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      if (gnt0 || gnt1) begin
        rdata    <= in_range ? bank[sel_addr] : '0;
        addr_err <= !in_range;
      end else begin
        rdata    <= '0;
        addr_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kernel_coeff_scheduler.sv
// Scoreboard bench for kernel_coeff_scheduler (SIZE=5, COEF_W=16, TIMEOUT=16).
module tb_kernel_coeff_scheduler;
  localparam int SIZE = 5;
  localparam int CW   = 16;
  localparam int N    = SIZE * SIZE;
  localparam int AW   = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          gen_done = 1'b0;
  logic [N*CW-1:0] gen_kernel = '0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          gen_reset, gen_enable, gnt0, gnt1, rvalid0, rvalid1, addr_err, kernel_valid, err;
  logic [CW-1:0] rdata;

  kernel_coeff_scheduler #(.SIZE(SIZE), .COEF_W(CW), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .gen_reset(gen_reset), .gen_enable(gen_enable),
    .gen_done(gen_done), .gen_kernel(gen_kernel), .req0(req0), .req1(req1), .addr0(addr0),
    .addr1(addr1), .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .addr_err(addr_err), .kernel_valid(kernel_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    logic [CW-1:0] data;
    bit          aerr;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  bit            mptr = 1'b0;
  bit            ready_m = 1'b0;
  logic [CW-1:0] kern [N];

  task automatic set_kernel(input int seed);
    for (int i = 0; i < N; i++) begin
      kern[i] = CW'(seed * 1000 + i * 37 - 400);
      gen_kernel[i*CW +: CW] = kern[i];
    end
  endtask

  task automatic rd_cycle(input bit r0, input logic [AW-1:0] a0, input bit r1,
                          input logic [AW-1:0] a1, input bit st);
    exp_t e;
    bit g0, g1;
    logic [AW-1:0] a;
    @(negedge clk);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; start = st;
    #1;
    g0 = ready_m && r0 && (!r1 || !mptr);
    g1 = ready_m && r1 && !g0;
    tests++;
    if ({gnt0, gnt1} !== {g0, g1}) begin
      fails++;
      $display("FAIL grant: got gnt0=%b gnt1=%b, expected %b %b", gnt0, gnt1, g0, g1);
    end
    if (g0 || g1) begin
      a = g1 ? a1 : a0;
      e.port = g1;
      e.aerr = (a >= N);
      e.data = e.aerr ? '0 : kern[a];
      sb.push_back(e);
      mptr = g0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (st) ready_m = 1'b0;
    tests++;
    if (g0 || g1) begin
      e = sb.pop_front();
      if ({rvalid0, rvalid1, rdata, addr_err} !== {!e.port, e.port, e.data, e.aerr}) begin
        fails++;
        $display("FAIL read: got rv0=%b rv1=%b rdata=%h aerr=%b, expected %b %b %h %b",
                 rvalid0, rvalid1, rdata, addr_err, !e.port, e.port, e.data, e.aerr);
      end
    end else if ({rvalid0, rvalid1, rdata, addr_err} !== '0) begin
      fails++;
      $display("FAIL idle_read: got rv0=%b rv1=%b rdata=%h aerr=%b, expected all zero",
               rvalid0, rvalid1, rdata, addr_err);
    end
  endtask

  task automatic idle_reqs();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // Enters with the state in CLR (just after the start edge) unless issue_start is set.
  task automatic run_gen(input bit issue_start, input int seed);
    int k;
    bit seen;
    gen_done = 1'b0;
    set_kernel(seed);
    if (issue_start) begin
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      ready_m = 1'b0;
    end
    k = 0;
    tests++;
    if (gen_reset !== 1'b1 || gen_enable !== 1'b0) begin
      fails++;
      $display("FAIL clr_pulse: got gen_reset=%b gen_enable=%b, expected 1 0", gen_reset, gen_enable);
    end
    @(posedge clk); #1; k = 1;
    tests++;
    if (gen_reset !== 1'b0 || gen_enable !== 1'b1) begin
      fails++;
      $display("FAIL gen_entry: got gen_reset=%b gen_enable=%b, expected 0 1", gen_reset, gen_enable);
    end
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; k = 2;
    tests++;
    if (gen_reset !== 1'b0 || gen_enable !== 1'b1) begin
      fails++;
      $display("FAIL start_in_gen: got gen_reset=%b gen_enable=%b, expected 0 1", gen_reset, gen_enable);
    end
    while (k < 31) begin
      @(posedge clk); #1; k++;
    end
    gen_done = 1'b1;
    seen = 1'b0;
    while (!seen && k < 60) begin
      @(posedge clk); #1; k++;
      if (k == 32) begin
        tests++;
        if (kernel_valid !== 1'b0) begin
          fails++;
          $display("FAIL load_cycle: got kernel_valid=%b, expected 0", kernel_valid);
        end
      end
      if (kernel_valid === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen || k != 33) begin
      fails++;
      $display("FAIL ready_latency: got cycle %0d (seen=%b), expected 33", k, seen);
    end
    ready_m = seen;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0 = 1'b1; addr0 = 5'd12;
    #12;
    tests++;
    if ({gen_reset, gen_enable, gnt0, gnt1, rvalid0, rvalid1, rdata, addr_err, kernel_valid, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rst=%b en=%b g=%b%b rv=%b%b rd=%h ae=%b kv=%b err=%b, expected 0",
               gen_reset, gen_enable, gnt0, gnt1, rvalid0, rvalid1, rdata, addr_err, kernel_valid, err);
    end
    @(negedge clk); reset_n = 1'b1;
    mptr = 1'b0; ready_m = 1'b0;
    rd_cycle(1'b1, 5'd12, 1'b0, '0, 1'b0);
    idle_reqs();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) rd_cycle(1'b1, AW'(i), 1'b1, AW'(i + 5), 1'b0);
    idle_reqs();
  endtask

  task automatic test_reads();
    rd_cycle(1'b1, 5'd12, 1'b0, '0, 1'b0);
    rd_cycle(1'b0, '0, 1'b1, 5'd25, 1'b0);
    rd_cycle(1'b0, '0, 1'b1, 5'd24, 1'b0);
    rd_cycle(1'b1, 5'd31, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++)
      rd_cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), 1'b0);
    idle_reqs();
  endtask

  task automatic test_start_in_ready();
    gen_done = 1'b0;
    rd_cycle(1'b1, 5'd12, 1'b0, '0, 1'b1);
    req0 = 1'b0;
    tests++;
    if (kernel_valid !== 1'b0) begin
      fails++;
      $display("FAIL regen_valid: got kernel_valid=%b, expected 0", kernel_valid);
    end
    run_gen(1'b0, 2);
    rd_cycle(1'b1, 5'd12, 1'b0, '0, 1'b0);
    rd_cycle(1'b0, '0, 1'b1, 5'd0, 1'b0);
    idle_reqs();
  endtask

  task automatic test_timeout();
    int k;
    bit err_seen;
    gen_done = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ready_m = 1'b0;
    k = 0;
`ifdef KSCHED_TIMEOUT_EN
    while (err !== 1'b1 && k < 40) begin
      @(posedge clk); #1; k++;
      if (k == 16) begin
        tests++;
        if (err !== 1'b0 || gen_enable !== 1'b1) begin
          fails++;
          $display("FAIL last_gen_cycle: got err=%b gen_enable=%b, expected 0 1", err, gen_enable);
        end
      end
    end
    tests++;
    if (k != 17 || gen_enable !== 1'b0) begin
      fails++;
      $display("FAIL timeout: got err at cycle %0d gen_enable=%b, expected 17 0", k, gen_enable);
    end
    rd_cycle(1'b1, 5'd3, 1'b0, '0, 1'b0);
    idle_reqs();
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    tests++;
    if (err !== 1'b0 || gen_reset !== 1'b1) begin
      fails++;
      $display("FAIL err_clear: got err=%b gen_reset=%b, expected 0 1", err, gen_reset);
    end
`else
    err_seen = 1'b0;
    while (k < 40) begin
      @(posedge clk); #1; k++;
      if (err !== 1'b0) err_seen = 1'b1;
    end
    tests++;
    if (err_seen || gen_enable !== 1'b1) begin
      fails++;
      $display("FAIL no_timeout: got err_seen=%b gen_enable=%b, expected 0 1", err_seen, gen_enable);
    end
`endif
  endtask

  task automatic test_reset_mid_gen();
    int k;
    k = 0;
    while (gen_enable !== 1'b1 && k < 5) begin
      @(posedge clk); #1; k++;
    end
    tests++;
    if (gen_enable !== 1'b1) begin
      fails++;
      $display("FAIL reach_gen: got gen_enable=%b, expected 1", gen_enable);
    end
    @(negedge clk); #2;
    reset_n = 1'b0;
    req0 = 1'b1; addr0 = 5'd12;
    #1;
    tests++;
    if ({gen_reset, gen_enable, gnt0, gnt1, rvalid0, rvalid1, rdata, addr_err, kernel_valid, err} !== '0) begin
      fails++;
      $display("FAIL async_reset: got rst=%b en=%b g=%b%b rv=%b%b rd=%h ae=%b kv=%b err=%b, expected 0",
               gen_reset, gen_enable, gnt0, gnt1, rvalid0, rvalid1, rdata, addr_err, kernel_valid, err);
    end
    @(negedge clk); reset_n = 1'b1;
    mptr = 1'b0; ready_m = 1'b0;
    rd_cycle(1'b1, 5'd12, 1'b0, '0, 1'b0);
    rd_cycle(1'b1, 5'd12, 1'b1, 5'd3, 1'b0);
    tests++;
    if (gen_enable !== 1'b0 || kernel_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got gen_enable=%b kernel_valid=%b, expected 0 0", gen_enable, kernel_valid);
    end
    idle_reqs();
  endtask

  initial begin
    test_reset();
    run_gen(1'b1, 1);
    test_round_robin();
    test_reads();
    test_start_in_ready();
    test_timeout();
    test_reset_mid_gen();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kernel_coeff_scheduler.md
KERNEL_COEFF_SCHEDULER -- requirements
Module: kernel_coeff_scheduler

Interface
REQ-001 SHALL have parameter SIZE, default 5, kernel edge length (odd, 3..9).
REQ-002 SHALL have parameter COEF_W, default 16, signed coefficient width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, max GEN-state cycles before error.
REQ-004 SHALL derive localparam N = SIZE*SIZE and AW = $clog2(N).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to (re)generate the kernel.
REQ-008 gen_reset  out  1  active-high clear pulse to the kernel generator.
REQ-009 gen_enable  out  1  enable to the kernel generator.
REQ-010 gen_done  in  1  generator completion flag (level, held until generator reset).
REQ-011 gen_kernel  in  N*COEF_W  flattened generator matrix; element i*SIZE+j at bits [(i*SIZE+j)*COEF_W +: COEF_W].
REQ-012 req0 / req1  in  1 each  coefficient read requests (req0 = convolution engine, req1 = readback).
REQ-013 addr0 / addr1  in  AW each  coefficient index per requester.
REQ-014 gnt0 / gnt1  out  1 each  grant, one-hot or zero.
REQ-015 rvalid0 / rvalid1  out  1 each  read data valid for the matching requester.
REQ-016 rdata  out  COEF_W  shared read data.
REQ-017 addr_err  out  1  granted address >= N (pulse, aligned with rvalid).
REQ-018 kernel_valid  out  1  high only in READY.
REQ-019 err  out  1  generation timeout flag (see Configuration).

Function
REQ-020 SHALL implement states IDLE, CLR, GEN, LOAD, READY, ERR.
REQ-021 IDLE/READY/ERR + start -> CLR; start in CLR, GEN, LOAD ignored.
REQ-022 CLR: gen_reset=1 exactly one cycle, then -> GEN.
REQ-023 GEN: gen_enable=1 every cycle; gen_done=1 -> LOAD.
REQ-024 LOAD: capture all N coefficients from gen_kernel into local register bank in one cycle, then -> READY.
REQ-025 Coefficient bank SHALL be written only in LOAD; contents persist through CLR/GEN (kernel_valid low during regeneration).
REQ-026 Grants SHALL be issued only in READY; requests in other states are not granted and not queued.
REQ-027 In READY, single request -> that requester granted same cycle (combinational gnt).
REQ-028 Both requesting -> round-robin; priority pointer toggles to the other requester after each grant; pointer = req0 after reset.
REQ-029 rdata, rvalidN, addr_err SHALL be registered: valid the cycle after the grant (latency 1), held low/zero otherwise.
REQ-030 Granted address >= N -> rdata = 0, addr_err = 1 for that cycle.
REQ-031 start asserted in READY with a simultaneous request -> request granted that cycle, state -> CLR next cycle.

Reset
REQ-032 reset_n low SHALL asynchronously force state IDLE, all outputs 0, coefficient bank 0, priority pointer req0, timeout counter 0.
REQ-033 Reset mid-GEN SHALL abandon generation; no grants until a later start completes.

Configuration
REQ-034 Macro KSCHED_TIMEOUT_EN defined: counter cleared on GEN entry, increments each GEN cycle; reaching TIMEOUT without gen_done -> ERR, err=1, gen_enable=0.
REQ-035 ERR SHALL hold err=1 until start (-> CLR, err cleared) or reset.
REQ-036 Macro undefined: no counter, err tied 0, GEN waits indefinitely, ERR unreachable.

Verification
REQ-037 Reset, start pulse, gen_done 30 cycles after gen_enable -> gen_reset 1 cycle, LOAD, kernel_valid=1 at cycle 33 after start.
REQ-038 READY, req0 addr0=12 alone -> gnt0 same cycle, rvalid0=1 next cycle with rdata=gen_kernel[12] value (center coef).
REQ-039 READY, req0 and req1 held 4 cycles -> grants alternate gnt0,gnt1,gnt0,gnt1.
REQ-040 READY, req1 addr1=25 (SIZE=5) -> rvalid1=1, rdata=0, addr_err=1.
REQ-041 KSCHED_TIMEOUT_EN, TIMEOUT=16, gen_done held 0 -> err=1 after 16 GEN cycles; start -> err=0, CLR.
REQ-042 reset_n low mid-GEN then high -> all outputs 0, state IDLE, req0 not granted.
